i2c_target_frontend: RTL and testbench
======================================

# i2c_target_frontend

Bit-level I2C target controller for the peripheral. Synchronizes raw SCL/SDA, detects START/STOP, and drives the downstream `byte_receiver` shift enable and serial bit. It reads the assembled byte back, counts bits, matches the 7-bit address, and generates ACK on SDA. Write transfers only; each received data byte is flagged to the register stage.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer flops on SCL and SDA (≥2).
- TARGET_ADDR, 7'h2A: 7-bit address this target answers.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- scl_in  in  1  raw SCL pin
- sda_in  in  1  raw SDA pin
- rx_byte  in  8  `out` of `byte_receiver`
- shift_en  out  1  to `byte_receiver.enable`; one-cycle pulse per sampled bit
- shift_bit  out  1  to `byte_receiver.in`; synchronized SDA at the sample point
- sda_oe  out  1  1 = pull SDA low (ACK)
- addr_match  out  1  one-cycle pulse: address byte matched with write
- byte_valid  out  1  one-cycle pulse: rx_byte holds a complete data byte
- start_det  out  1  one-cycle pulse on START or repeated START
- stop_det  out  1  one-cycle pulse on STOP
- busy  out  1  high from START to STOP

## Operation
- scl_s/sda_s: SYNC_STAGES flops each, reset to 1; previous-sample flops also reset to 1.
- Events, from sync outputs: scl_rise, scl_fall; START = sda_s 1→0 while scl_s and scl_prev both 1; STOP = sda_s 0→1 under the same condition.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE. bit_cnt 4 bits, counts 0..8.
- START, any state: go to ADDR, bit_cnt=0, sda_oe=0, busy=1, start_det pulse. STOP, any state: go to IDLE, sda_oe=0, busy=0, stop_det pulse. START/STOP take priority over every other transition.
- ADDR/DATA on scl_rise with bit_cnt<8:
  - shift_en=1, shift_bit=sda_s, bit_cnt++.
- ADDR on scl_fall with bit_cnt==8:
  - If rx_byte[7:1]==TARGET_ADDR and rx_byte[0]==0: sda_oe=1, addr_match pulse, go to ADDR_ACK.
  - Otherwise, including read requests: stay released, go to IGNORE.
- DATA on scl_fall with bit_cnt==8: byte_valid pulse, sda_oe=1, go to DATA_ACK.
- ADDR_ACK/DATA_ACK on scl_fall (end of 9th clock): sda_oe=0, bit_cnt=0, go to DATA.
- IGNORE: no shift_en, no sda_oe; leaves only on START or STOP.
- SCL edges in IDLE are ignored.

## Timing
- Reset values: all outputs 0; state IDLE; bit_cnt 0.
- Pin to event latency: SYNC_STAGES+1 clk cycles.
- shift_en/shift_bit are asserted in the scl_rise cycle. `byte_receiver` updates on the next edge, so rx_byte is stable ≥1 cycle before the following scl_fall.
- sda_oe changes in the scl_fall event cycle. It is registered, so the pin changes one clk later.
- Requirement: SCL high and low phases each ≥ SYNC_STAGES+3 clk cycles.
- All pulses are exactly one cycle wide.
- Reset mid-transfer returns to IDLE with SDA released at the next clk edge.

## Structure
- Package `i2c_pkg`:
  - state enum.
  - Constant I2C_BITS_PER_BYTE=8.
  - Write-direction constant RW_WRITE=1'b0.
- Sub-module `i2c_sync_edge`: synchronizer plus previous-sample flop, outputs level, rise, and fall. Instantiated once for SCL and once for SDA.
- Top-level bench instantiates this block with `byte_receiver` wired per Interface.

## Test plan
- Bus idle 1/1, then reset: all outputs 0; no events for 20 cycles.
- START, address 0x2A+W (byte 0x54): 8 shift_en pulses with bits 0,1,0,1,0,1,0,0; addr_match pulse; sda_oe high for exactly the 9th SCL clock.
- After the match, data 0xA5 then 0x3C, then STOP:
  - byte_valid twice, with rx_byte 0xA5 and 0x3C.
  - ACK on each byte.
  - stop_det pulse; busy 0.
- Address 0x2B+W, or 0x2A+R (0x55): no addr_match, sda_oe stays 0; later data bytes give no shift_en and no byte_valid until STOP.
- Repeated START after bit 3 of a data byte: start_det pulse, bit_cnt resets, and the next 8 bits are treated as an address.
- Reset asserted while sda_oe=1 during ACK: sda_oe=0 next cycle, state IDLE, busy=0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared FSM state type and bus constants for the I2C target front-end.
package i2c_pkg;

    localparam int   I2C_BITS_PER_BYTE = 8;
    localparam logic RW_WRITE          = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one raw bus pin plus a previous-sample flop,
// giving the synchronized level and single-cycle rise/fall strobes.
module i2c_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop capture its pre-edge input, forming a true shift chain.
        if (reset) begin
            // NOTE: reset to 1 (idle bus level) so leaving reset never fakes an edge, START or STOP.
            chain <= '1;
            prev  <= 1'b1;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/i2c_target_frontend.sv
// Bit-level I2C write-only target: START/STOP detection, bit shifting into an
// external byte_receiver, 7-bit address match and ACK generation.
module i2c_target_frontend
    import i2c_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] TARGET_ADDR = 7'h2A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    input  logic [7:0] rx_byte,
    output logic       shift_en,
    output logic       shift_bit,
    output logic       sda_oe,
    output logic       addr_match,
    output logic       byte_valid,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    localparam logic [3:0] BIT_FULL = 4'(I2C_BITS_PER_BYTE);

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk   (clk),
        .reset (reset),
        .din   (scl_in),
        .level (scl_s),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sda_in),
        .level (sda_s),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    // scl_s & ~scl_rise is exactly "SCL high now and on the previous sample".
    logic start_ev, stop_ev;
    assign start_ev = sda_fall & scl_s & ~scl_rise;
    assign stop_ev  = sda_rise & scl_s & ~scl_rise;

    state_t     state, state_n;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic       sda_oe_n, busy_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            sda_oe  <= sda_oe_n;
            busy    <= busy_n;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        sda_oe_n   = sda_oe;
        busy_n     = busy;
        shift_en   = 1'b0;
        shift_bit  = 1'b0;
        addr_match = 1'b0;
        byte_valid = 1'b0;
        start_det  = 1'b0;
        stop_det   = 1'b0;

        // Strobes are gated during reset so every output reads 0 while it is held.
        if (!reset) begin
            if (start_ev) begin
                state_n   = ADDR;
                bit_cnt_n = '0;
                sda_oe_n  = 1'b0;
                busy_n    = 1'b1;
                start_det = 1'b1;
            end else if (stop_ev) begin
                state_n  = IDLE;
                sda_oe_n = 1'b0;
                busy_n   = 1'b0;
                stop_det = 1'b1;
            end else begin
                unique case (state)
                    ADDR, DATA: begin
                        if (scl_rise && bit_cnt < BIT_FULL) begin
                            shift_en  = 1'b1;
                            shift_bit = sda_s;
                            bit_cnt_n = bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == BIT_FULL) begin
                            if (state == DATA) begin
                                byte_valid = 1'b1;
                                sda_oe_n   = 1'b1;
                                state_n    = DATA_ACK;
                            end else if (rx_byte[7:1] == TARGET_ADDR && rx_byte[0] == RW_WRITE) begin
                                addr_match = 1'b1;
                                sda_oe_n   = 1'b1;
                                state_n    = ADDR_ACK;
                            end else begin
                                state_n = IGNORE;
                            end
                        end
                    end
                    ADDR_ACK, DATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = '0;
                            state_n   = DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_frontend.sv
// Directed bench for i2c_target_frontend: drives an I2C master on the pins,
// models byte_receiver, and checks strobes, ACKs and reset behaviour.
module tb_i2c_target_frontend;
    import i2c_pkg::*;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    logic [7:0] rx_byte;
    logic       scl_in, sda_in;
    logic       shift_en, shift_bit, sda_oe, addr_match, byte_valid;
    logic       start_det, stop_det, busy;

    assign scl_in = scl_drv;
    assign sda_in = sda_drv & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_frontend #(.SYNC_STAGES(2), .TARGET_ADDR(7'h2A)) dut (
        .clk        (clk),
        .reset      (reset),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .rx_byte    (rx_byte),
        .shift_en   (shift_en),
        .shift_bit  (shift_bit),
        .sda_oe     (sda_oe),
        .addr_match (addr_match),
        .byte_valid (byte_valid),
        .start_det  (start_det),
        .stop_det   (stop_det),
        .busy       (busy)
    );

    // byte_receiver model: MSB-first shift register
    always @(posedge clk) begin
        if (reset) rx_byte <= '0;
        else if (shift_en) rx_byte <= {rx_byte[6:0], shift_bit};
    end

    // Free-running event monitor
    int          n_shift = 0, n_addr = 0, n_bv = 0, n_start = 0, n_stop = 0;
    int          n_wide = 0, n_oe_scl = 0;
    logic [7:0]  shift_hist = '0;
    logic [15:0] bv_hist = '0;
    logic [4:0]  pulses_q = '0;
    logic        scl_q = 1'b1;

    always @(negedge clk) begin
        scl_q    <= scl_in;
        pulses_q <= {shift_en, addr_match, byte_valid, start_det, stop_det};
        if (shift_en) begin
            n_shift    <= n_shift + 1;
            shift_hist <= {shift_hist[6:0], shift_bit};
        end
        if (addr_match) n_addr <= n_addr + 1;
        if (byte_valid) begin
            n_bv    <= n_bv + 1;
            bv_hist <= {bv_hist[7:0], rx_byte};
        end
        if (start_det) n_start <= n_start + 1;
        if (stop_det)  n_stop  <= n_stop + 1;
        if ((pulses_q & {shift_en, addr_match, byte_valid, start_det, stop_det}) != 5'b0)
            n_wide <= n_wide + 1;
        if (sda_oe && scl_in && !scl_q) n_oe_scl <= n_oe_scl + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Bus master primitives; every phase lasts Q clk cycles
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_drv = 1'b0; wait_cyc(Q);
        scl_drv = 1'b0; wait_cyc(Q);
    endtask

    task automatic bus_rstart();
        sda_drv = 1'b1; wait_cyc(Q);
        scl_drv = 1'b1; wait_cyc(Q);
        sda_drv = 1'b0; wait_cyc(Q);
        scl_drv = 1'b0; wait_cyc(Q);
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; wait_cyc(Q);
        scl_drv = 1'b1; wait_cyc(Q);
        sda_drv = 1'b1; wait_cyc(Q);
    endtask

    task automatic bus_bit(input logic b);
        sda_drv = b;    wait_cyc(Q);
        scl_drv = 1'b1; wait_cyc(Q);
        scl_drv = 1'b0; wait_cyc(Q);
    endtask

    task automatic bus_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bus_bit(b[i]);
    endtask

    task automatic bus_ack(output logic ack);
        sda_drv = 1'b1; wait_cyc(Q);
        scl_drv = 1'b1; wait_cyc(Q / 2);
        ack = sda_in;   wait_cyc(Q - Q / 2);
        scl_drv = 1'b0; wait_cyc(Q);
    endtask

    task automatic test_reset();
        int ev0;
        scl_drv = 1'b1; sda_drv = 1'b1; reset = 1'b1;
        wait_cyc(4);
        reset = 1'b0;
        wait_cyc(1);
        n_cmp++; if (shift_en !== 1'b0) begin n_bad++; $display("FAIL reset_shift_en: got %b want 0", shift_en); end
        n_cmp++; if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        n_cmp++; if (addr_match !== 1'b0) begin n_bad++; $display("FAIL reset_addr_match: got %b want 0", addr_match); end
        n_cmp++; if (byte_valid !== 1'b0) begin n_bad++; $display("FAIL reset_byte_valid: got %b want 0", byte_valid); end
        n_cmp++; if ({start_det, stop_det} !== 2'b00) begin n_bad++; $display("FAIL reset_start_stop: got %b want 00", {start_det, stop_det}); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        ev0 = n_shift + n_addr + n_bv + n_start + n_stop;
        wait_cyc(20);
        n_cmp++; if (n_shift + n_addr + n_bv + n_start + n_stop - ev0 !== 0) begin
            n_bad++; $display("FAIL idle_events: got %0d want 0", n_shift + n_addr + n_bv + n_start + n_stop - ev0);
        end
    endtask

    task automatic test_addr_write();
        int s0, a0, o0, st0;
        logic ack;
        st0 = n_start;
        bus_start();
        n_cmp++; if (n_start - st0 !== 1) begin n_bad++; $display("FAIL start_det: got %0d want 1", n_start - st0); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_after_start: got %b want 1", busy); end
        s0 = n_shift; a0 = n_addr; o0 = n_oe_scl;
        bus_byte(8'h54);
        n_cmp++; if (n_shift - s0 !== 8) begin n_bad++; $display("FAIL addr_shift_cnt: got %0d want 8", n_shift - s0); end
        n_cmp++; if (shift_hist !== 8'h54) begin n_bad++; $display("FAIL addr_bits: got %h want 54", shift_hist); end
        n_cmp++; if (sda_oe !== 1'b1) begin n_bad++; $display("FAIL addr_ack_oe: got %b want 1", sda_oe); end
        bus_ack(ack);
        n_cmp++; if (n_addr - a0 !== 1) begin n_bad++; $display("FAIL addr_match_cnt: got %0d want 1", n_addr - a0); end
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL addr_ack: got %b want 0", ack); end
        n_cmp++; if (n_oe_scl - o0 !== 1) begin n_bad++; $display("FAIL addr_oe_clocks: got %0d want 1", n_oe_scl - o0); end
        n_cmp++; if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL addr_oe_release: got %b want 0", sda_oe); end
    endtask

    task automatic test_data_write();
        int b0, sp0;
        logic ack1, ack2;
        b0 = n_bv; sp0 = n_stop;
        bus_byte(8'hA5); bus_ack(ack1);
        bus_byte(8'h3C); bus_ack(ack2);
        bus_stop();
        n_cmp++; if (n_bv - b0 !== 2) begin n_bad++; $display("FAIL data_byte_valid_cnt: got %0d want 2", n_bv - b0); end
        n_cmp++; if (bv_hist !== 16'hA53C) begin n_bad++; $display("FAIL data_bytes: got %h want a53c", bv_hist); end
        n_cmp++; if ({ack1, ack2} !== 2'b00) begin n_bad++; $display("FAIL data_acks: got %b want 00", {ack1, ack2}); end
        n_cmp++; if (n_stop - sp0 !== 1) begin n_bad++; $display("FAIL stop_det: got %0d want 1", n_stop - sp0); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_stop: got %b want 0", busy); end
    endtask

    task automatic test_addr_nomatch(input logic [7:0] addr_byte, input string tag);
        int a0, s0, b0, o0;
        logic ack, ack_d;
        a0 = n_addr; o0 = n_oe_scl;
        bus_start();
        bus_byte(addr_byte); bus_ack(ack);
        s0 = n_shift; b0 = n_bv;
        bus_byte(8'h81); bus_ack(ack_d);
        bus_stop();
        n_cmp++; if (n_addr - a0 !== 0) begin n_bad++; $display("FAIL %s_addr_match: got %0d want 0", tag, n_addr - a0); end
        n_cmp++; if ({ack, ack_d} !== 2'b11) begin n_bad++; $display("FAIL %s_nack: got %b want 11", tag, {ack, ack_d}); end
        n_cmp++; if (n_oe_scl - o0 !== 0) begin n_bad++; $display("FAIL %s_oe_clocks: got %0d want 0", tag, n_oe_scl - o0); end
        n_cmp++; if (n_shift - s0 !== 0) begin n_bad++; $display("FAIL %s_data_shift: got %0d want 0", tag, n_shift - s0); end
        n_cmp++; if (n_bv - b0 !== 0) begin n_bad++; $display("FAIL %s_byte_valid: got %0d want 0", tag, n_bv - b0); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy: got %b want 0", tag, busy); end
    endtask

    task automatic test_repeated_start();
        int st0, s0, a0, b0;
        logic ack;
        bus_start();
        bus_byte(8'h54); bus_ack(ack);
        bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1);
        st0 = n_start;
        bus_rstart();
        n_cmp++; if (n_start - st0 !== 1) begin n_bad++; $display("FAIL rstart_start_det: got %0d want 1", n_start - st0); end
        n_cmp++; if (dut.bit_cnt !== 4'd0) begin n_bad++; $display("FAIL rstart_bit_cnt: got %0d want 0", dut.bit_cnt); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstart_busy: got %b want 1", busy); end
        s0 = n_shift; a0 = n_addr;
        bus_byte(8'h54); bus_ack(ack);
        n_cmp++; if (n_shift - s0 !== 8) begin n_bad++; $display("FAIL rstart_shift_cnt: got %0d want 8", n_shift - s0); end
        n_cmp++; if (n_addr - a0 !== 1) begin n_bad++; $display("FAIL rstart_addr_match: got %0d want 1", n_addr - a0); end
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rstart_ack: got %b want 0", ack); end
        b0 = n_bv;
        bus_byte(8'h11); bus_ack(ack);
        n_cmp++; if (n_bv - b0 !== 1 || bv_hist[7:0] !== 8'h11) begin
            n_bad++; $display("FAIL rstart_data: got cnt %0d byte %h want cnt 1 byte 11", n_bv - b0, bv_hist[7:0]);
        end
        bus_stop();
    endtask

    task automatic test_reset_during_ack();
        bus_start();
        bus_byte(8'h54);
        n_cmp++; if (sda_oe !== 1'b1) begin n_bad++; $display("FAIL rst_pre_oe: got %b want 1", sda_oe); end
        reset = 1'b1;
        wait_cyc(1);
        n_cmp++; if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL rst_oe: got %b want 0", sda_oe); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL rst_state: got %0d want %0d", dut.state, IDLE); end
        reset = 1'b0;
        sda_drv = 1'b1; scl_drv = 1'b1;
        wait_cyc(10);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy_after: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_addr_write();
        test_data_write();
        test_addr_nomatch(8'h56, "addr2b");
        test_addr_nomatch(8'h55, "read2a");
        test_repeated_start();
        test_reset_during_ack();
        n_cmp++; if (n_wide !== 0) begin n_bad++; $display("FAIL pulse_width: got %0d wide pulses want 0", n_wide); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
